// File: rtl/lsu_riscv.sv
// rtl/lsu_riscv.sv - load/store unit: one req/ready memory handshake per access, lanes and load extension
// Optional build macro LSU_MISALIGN_TRAP_EN adds misalign_o and refuses misaligned H/HU/W accesses.
module lsu_riscv #(
    parameter int ADDR_W            = 32,
    parameter int TIMEOUT_EN_CYCLES = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [2:0]        core_size_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [31:0]       core_wd_i,
    output logic [31:0]       core_rd_o,
    output logic              core_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wd_o,
    input  logic [31:0]       mem_rd_i,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic              misalign_o,
`endif
    input  logic              mem_ready_i
);

    if (TIMEOUT_EN_CYCLES != 0) begin : g_timeout_unsupported
        $error("lsu_riscv: TIMEOUT_EN_CYCLES must be 0");
    end

    typedef enum logic {IDLE, REQ} state_t;

    state_t      state;
    logic        done_q;
    logic [2:0]  size_q;
    logic [1:0]  off_q;

    logic        size_ok;
    logic [3:0]  be_n;
    logic [31:0] wd_n;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_data;

    assign core_stall_o = core_req_i & ~done_q;

    // Byte enables and replicated store lanes for the incoming access
    always_comb begin
        size_ok = 1'b1;
        be_n    = 4'b0000;
        wd_n    = 32'd0;
        case (core_size_i)
            3'd0, 3'd4: begin
                be_n = 4'b0001 << core_addr_i[1:0];
                wd_n = {4{core_wd_i[7:0]}};
            end
            3'd1, 3'd5: begin
                be_n = core_addr_i[1] ? 4'b1100 : 4'b0011;
                wd_n = {2{core_wd_i[15:0]}};
            end
            3'd2: begin
                be_n = 4'b1111;
                wd_n = core_wd_i;
            end
            default: size_ok = 1'b0;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;
    always_comb begin
        misalign = 1'b0;
        if ((core_size_i == 3'd1 || core_size_i == 3'd5) && core_addr_i[0])
            misalign = 1'b1;
        if (core_size_i == 3'd2 && core_addr_i[1:0] != 2'b00)
            misalign = 1'b1;
    end
`endif

    // Load extraction uses the fields latched at request time
    always_comb begin
        case (off_q)
            2'd0:    byte_sel = mem_rd_i[7:0];
            2'd1:    byte_sel = mem_rd_i[15:8];
            2'd2:    byte_sel = mem_rd_i[23:16];
            default: byte_sel = mem_rd_i[31:24];
        endcase
        half_sel = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        case (size_q)
            3'd0:    ld_data = {{24{byte_sel[7]}}, byte_sel};
            3'd4:    ld_data = {24'd0, byte_sel};
            3'd1:    ld_data = {{16{half_sel[15]}}, half_sel};
            3'd5:    ld_data = {16'd0, half_sel};
            default: ld_data = mem_rd_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= IDLE;
            done_q     <= 1'b0;
            size_q     <= 3'd0;
            off_q      <= 2'd0;
            core_rd_o  <= 32'd0;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_be_o   <= 4'b0000;
            mem_addr_o <= '0;
            mem_wd_o   <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_o <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_o <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (core_req_i && !done_q) begin
                        if (!size_ok) begin
                            done_q    <= 1'b1;
                            core_rd_o <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
                        end else if (misalign) begin
                            done_q     <= 1'b1;
                            misalign_o <= 1'b1;
                            core_rd_o  <= 32'd0;
`endif
                        end else begin
                            state      <= REQ;
                            size_q     <= core_size_i;
                            off_q      <= core_addr_i[1:0];
                            mem_req_o  <= 1'b1;
                            mem_we_o   <= core_we_i;
                            mem_be_o   <= be_n;
                            mem_addr_o <= {core_addr_i[ADDR_W-1:2], 2'b00};
                            mem_wd_o   <= core_we_i ? wd_n : 32'd0;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready_i) begin
                        if (!mem_we_o)
                            core_rd_o <= ld_data;
                        done_q     <= 1'b1;
                        state      <= IDLE;
                        mem_req_o  <= 1'b0;
                        mem_we_o   <= 1'b0;
                        mem_be_o   <= 4'b0000;
                        mem_addr_o <= '0;
                        mem_wd_o   <= 32'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
